clk_div_gen: RTL
================

# clk_div_gen

Synthesizable, multi-channel programmable clock-pattern generator. Each channel derives a divided square wave of programmable period and high time from the single system clock. Channels support glitch-free start and stop, shadowed reconfiguration applied only at period boundaries, and a common phase-align strobe. Testbenches and datapath blocks use it wherever a free-running, enable-controlled clock or strobe is needed, without behavioral delays.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- DIV_W, 16: width of the period and high-time counts
- DEF_PERIOD, 4: reset value of every channel's period (cycles)
- DEF_HIGH, 2: reset value of every channel's high time (cycles)

- clk_i  in  1  system clock; all logic is on the rising edge
- rst_i  in  1  synchronous, active-high reset
- enable_i  in  NUM_CH  per-channel run request
- sync_i  in  1  one-cycle strobe; phase-aligns all running channels
- cfg_we_i  in  1  configuration write strobe
- cfg_ch_i  in  4  target channel of the write
- cfg_period_i  in  DIV_W  new period P, in cycles
- cfg_high_i  in  DIV_W  new high time H, in cycles
- clk_out_o  out  NUM_CH  registered divided clock per channel
- tick_o  out  NUM_CH  one-cycle pulse in the first high cycle of each period
- cfg_pend_o  out  NUM_CH  shadow configuration written but not yet active
- run_o  out  NUM_CH  channel is in RUN or STOP state

## Operation
- Per channel: shadow {P,H}, active {P,H}, counter cnt (DIV_W bits), and a state machine with states IDLE, RUN, STOP.
- Config clamping is applied when the active set loads:
  - P < 2 is treated as 2.
  - H = 0 is treated as 1.
  - H >= P is treated as P-1.
  - Every period therefore has at least one high cycle and one low cycle.
- Config write: when cfg_we_i = 1 and cfg_ch_i < NUM_CH, the shadow is loaded and cfg_pend_o is set. When cfg_ch_i >= NUM_CH, the write is ignored.
- Active set load: active <= shadow, and cfg_pend_o is cleared. This happens only at period start: on IDLE->RUN, on a wrap, or on sync_i.
- Write in the same cycle as a load: the load uses the old shadow value, the new value lands in the shadow, and cfg_pend_o stays 1.
- IDLE: cnt = 0 and clk_out_o = 0. When enable_i = 1 is sampled: load active set, go to RUN, cnt = 0.
- RUN: cnt increments each cycle. At cnt = P-1 it wraps to 0 and the active set reloads.
  - clk_out_o = 1 while cnt < H, else 0 (decoded from the registered next cnt, so the output is registered).
  - tick_o = 1 when cnt = 0.
  - If enable_i = 0, go to STOP.
- STOP: counting continues. enable_i = 1 returns to RUN with no interruption. Reaching cnt = P-1 with enable_i = 0 goes to IDLE, so the last low phase always completes and no runt pulse is produced.
- sync_i:
  - Every channel with enable_i = 1 (RUN, STOP or IDLE) goes to RUN with cnt = 0 and loads its active set.
  - Channels in STOP with enable_i = 0 go to IDLE immediately, output low.
  - sync_i takes priority over a wrap in the same cycle.
- Reset: all channels go to IDLE. shadow = active = {DEF_PERIOD, DEF_HIGH}. cnt = 0. clk_out_o, tick_o, cfg_pend_o and run_o are all 0.
- rst_i asserted mid-period aborts immediately; outputs are 0 in the cycle after the reset edge.

## Timing
- Start latency: with enable_i sampled high at edge n, clk_out_o, tick_o and run_o are 1 after edge n.
- In steady state, clk_out_o is high for exactly H cycles and low for P-H cycles. Period is P cycles; no cycle-to-cycle jitter.
- A config written in period k takes effect at the start of period k+1. If written in the wrap cycle (cnt = P-1), it takes effect at period k+2.
- Stop: clk_out_o falls at the programmed H boundary. run_o drops on the edge after cnt = P-1.
- sync_i sampled at edge n: all enabled channels show cnt = 0, clk_out_o = 1 and tick_o = 1 after edge n, in lockstep.
- cnt never exceeds P_active-1. Full-scale P = 2^DIV_W-1 is supported with no overflow.

## Test plan
- Reset defaults: hold rst_i for 3 cycles, then enable_i = 0001 -> ch0 output 1,1,0,0 repeating; tick_o every 4th cycle; other channels at 0.
- Reconfigure mid-run: ch1 running P=4 H=2; write P=6 H=1 at cnt=1 -> cfg_pend_o[1] = 1 until the next wrap; next period is 1 high, 5 low.
- Clamping: write P=1 H=0, then P=5 H=9 -> first gives a 1-high/1-low pattern; second gives 4 high, 1 low.
- Glitch-free stop: P=8 H=4, drop enable_i at cnt=2 -> high phase ends at cnt=3, low phase continues through cnt=7, then IDLE; re-enable at cnt=5 -> no gap.
- Sync: ch0 P=4, ch2 P=6 at arbitrary phases; pulse sync_i -> both tick_o on the same cycle; sync_i coinciding with a wrap loads config once.
- Reset mid-high-phase, plus a write to cfg_ch_i = 7 with NUM_CH = 4 -> all outputs 0 the next cycle; out-of-range write changes nothing.

Source files
------------

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - control, configuration and output bundle for clk_div_gen
//
// Purpose: groups the per-channel run/sync controls, the configuration write
// port and the divided-clock outputs so they travel as one port.
// Ports (all logic):
//   enable_i     [NUM_CH]  per-channel run request
//   sync_i                 one-cycle phase-align strobe
//   cfg_we_i               configuration write strobe
//   cfg_ch_i     [4]       channel addressed by the write
//   cfg_period_i [DIV_W]   new period in cycles
//   cfg_high_i   [DIV_W]   new high time in cycles
//   clk_out_o    [NUM_CH]  divided clock per channel
//   tick_o       [NUM_CH]  pulse in the first high cycle of each period
//   cfg_pend_o   [NUM_CH]  shadow written but not yet active
//   run_o        [NUM_CH]  channel in RUN or STOP
// master: the side that drives controls; slave: the generator.
interface clk_div_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
) ();
  logic [NUM_CH-1:0] enable_i;
  logic              sync_i;
  logic              cfg_we_i;
  logic [3:0]        cfg_ch_i;
  logic [DIV_W-1:0]  cfg_period_i;
  logic [DIV_W-1:0]  cfg_high_i;
  logic [NUM_CH-1:0] clk_out_o;
  logic [NUM_CH-1:0] tick_o;
  logic [NUM_CH-1:0] cfg_pend_o;
  logic [NUM_CH-1:0] run_o;

  modport master (
    output enable_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i,
    input  clk_out_o, tick_o, cfg_pend_o, run_o
  );

  modport slave (
    input  enable_i, sync_i, cfg_we_i, cfg_ch_i, cfg_period_i, cfg_high_i,
    output clk_out_o, tick_o, cfg_pend_o, run_o
  );
endinterface

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - multi-channel programmable clock-pattern generator
//
// Purpose: each channel produces a registered square wave of period P and
// high time H, with glitch-free start/stop, shadowed configuration that
// becomes active only at a period start, and a common phase-align strobe.
// Ports:
//   clk_i  system clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    clk_div_gen_if.slave (controls, config write, outputs)
module clk_div_gen #(
  parameter int NUM_CH     = 4,
  parameter int DIV_W      = 16,
  parameter int DEF_PERIOD = 4,
  parameter int DEF_HIGH   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  clk_div_gen_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] MIN_P = DIV_W'(2);

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [DIV_W-1:0]  act_p_q [NUM_CH];
  logic [DIV_W-1:0]  act_p_d [NUM_CH];
  logic [DIV_W-1:0]  act_h_q [NUM_CH];
  logic [DIV_W-1:0]  act_h_d [NUM_CH];
  logic [DIV_W-1:0]  shd_p_q [NUM_CH];
  logic [DIV_W-1:0]  shd_p_d [NUM_CH];
  logic [DIV_W-1:0]  shd_h_q [NUM_CH];
  logic [DIV_W-1:0]  shd_h_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] run_w;

  function automatic logic [DIV_W-1:0] clamp_p(input logic [DIV_W-1:0] p);
    return (p < MIN_P) ? MIN_P : p;
  endfunction

  // p_c is the already-clamped period, so the result is always 1..p_c-1.
  function automatic logic [DIV_W-1:0] clamp_h(input logic [DIV_W-1:0] p_c,
                                              input logic [DIV_W-1:0] h);
    if (h == '0)  return ONE;
    if (h >= p_c) return p_c - ONE;
    return h;
  endfunction

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic load;
      logic wrap;
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      act_p_d[c] = act_p_q[c];
      act_h_d[c] = act_h_q[c];
      shd_p_d[c] = shd_p_q[c];
      shd_h_d[c] = shd_h_q[c];
      pend_d[c]  = pend_q[c];
      run_w[c]   = (state_q[c] != IDLE);
      load       = 1'b0;
      wrap       = (cnt_q[c] == act_p_q[c] - ONE);

      case (state_q[c])
        IDLE: begin
          if (bus.enable_i[c]) begin
            state_d[c] = RUN;
            cnt_d[c]   = '0;
            load       = 1'b1;
          end
        end
        RUN, STOP: begin
          if (wrap) begin
            cnt_d[c] = '0;
            // A channel not requested at the period end retires here, so the
            // final low phase is always complete and no extra period starts.
            if (bus.enable_i[c]) begin
              state_d[c] = RUN;
              load       = 1'b1;
            end else begin
              state_d[c] = IDLE;
            end
          end else begin
            cnt_d[c]   = cnt_q[c] + ONE;
            state_d[c] = bus.enable_i[c] ? RUN : STOP;
          end
        end
        default: begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
        end
      endcase

      // Sync overrides whatever the period logic decided, including a wrap,
      // so a coinciding wrap still yields exactly one active-set load.
      if (bus.sync_i) begin
        if (bus.enable_i[c]) begin
          state_d[c] = RUN;
          cnt_d[c]   = '0;
          load       = 1'b1;
        end else if (state_q[c] != IDLE) begin
          state_d[c] = IDLE;
          cnt_d[c]   = '0;
          load       = 1'b0;
        end
      end

      if (load) begin
        act_p_d[c] = clamp_p(shd_p_q[c]);
        act_h_d[c] = clamp_h(clamp_p(shd_p_q[c]), shd_h_q[c]);
        pend_d[c]  = 1'b0;
      end

      // Applied after the load so a same-cycle write stays pending.
      if (bus.cfg_we_i && (bus.cfg_ch_i == 4'(c))) begin
        shd_p_d[c] = bus.cfg_period_i;
        shd_h_d[c] = bus.cfg_high_i;
        pend_d[c]  = 1'b1;
      end

      // Outputs decode the next count so they come straight from flops.
      clk_d[c]  = (state_d[c] != IDLE) && (cnt_d[c] < act_h_d[c]);
      tick_d[c] = (state_d[c] != IDLE) && (cnt_d[c] == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        act_p_q[c] <= DIV_W'(DEF_PERIOD);
        act_h_q[c] <= DIV_W'(DEF_HIGH);
        shd_p_q[c] <= DIV_W'(DEF_PERIOD);
        shd_h_q[c] <= DIV_W'(DEF_HIGH);
      end
      pend_q <= '0;
      clk_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        act_p_q[c] <= act_p_d[c];
        act_h_q[c] <= act_h_d[c];
        shd_p_q[c] <= shd_p_d[c];
        shd_h_q[c] <= shd_h_d[c];
      end
      pend_q <= pend_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign bus.clk_out_o  = clk_q;
  assign bus.tick_o     = tick_q;
  assign bus.cfg_pend_o = pend_q;
  assign bus.run_o      = run_w;

endmodule
